// File: rtl/bcd_conv_sched_if.sv
// rtl/bcd_conv_sched_if.sv - requester, converter and response bundle for bcd_conv_sched
interface bcd_conv_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               cv_clr;
  logic               cv_shift;
  logic               cv_bit;
  logic [15:0]        cv_bcd;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_bcd;
  logic               rsp_ovf;

  modport slave (
    input  req, req_data, cv_bcd, rsp_rdy,
    output gnt, busy, cv_clr, cv_shift, cv_bit, rsp_vld, rsp_id, rsp_bcd, rsp_ovf
  );

  modport master (
    output req, req_data, cv_bcd, rsp_rdy,
    input  gnt, busy, cv_clr, cv_shift, cv_bit, rsp_vld, rsp_id, rsp_bcd, rsp_ovf
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler for a shared serial binary-to-BCD converter
// Optional: BCD_SCHED_OVF_SAT_EN saturates overflowed results to 16'h9999.
module bcd_conv_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic              clk,
  input logic              rst_n,
  bcd_conv_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    sh_q, sh_d;
  logic [15:0]    rsp_bcd_q, rsp_bcd_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           rsp_ovf_q, rsp_ovf_d;

  logic [2*NREQ-1:0] req_dbl;
  logic              found;
  logic [IDW-1:0]    pick;
  logic [15:0]       opnd;
  int                sum;

  // Rotate the request vector by the pointer so the lowest set bit is the winner.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    opnd    = '0;
    sum     = 0;
    req_dbl = {bus.req, bus.req} >> ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_dbl[i]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        pick  = IDW'(sum);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick) == i) opnd = bus.req_data[i*16 +: 16];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    rsp_id_d     = rsp_id_q;
    rsp_bcd_d    = rsp_bcd_q;
    rsp_ovf_d    = rsp_ovf_q;
    bus.gnt      = '0;
    bus.cv_clr   = 1'b0;
    bus.cv_shift = 1'b0;
    bus.cv_bit   = 1'b0;
    bus.rsp_vld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && rst_n) begin
          bus.gnt    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          bus.cv_clr = 1'b1;
          sh_d       = opnd;
          id_d       = pick;
          ovf_d      = (opnd > 16'd9999);
          cnt_d      = 4'd15;
          ptr_d      = (int'(pick) == NREQ-1) ? '0 : pick + 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bus.cv_shift = 1'b1;
        bus.cv_bit   = sh_q[15];
        sh_d         = {sh_q[14:0], 1'b0};
        cnt_d        = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_id_d  = id_q;
        rsp_ovf_d = ovf_q;
`ifdef BCD_SCHED_OVF_SAT_EN
        rsp_bcd_d = ovf_q ? 16'h9999 : bus.cv_bcd;
`else
        rsp_bcd_d = bus.cv_bcd;
`endif
        state_d   = RESP;
      end
      RESP: begin
        bus.rsp_vld = 1'b1;
        if (bus.rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rsp_id_q  <= '0;
      rsp_bcd_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rsp_id_q  <= rsp_id_d;
      rsp_bcd_q <= rsp_bcd_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_bcd = rsp_bcd_q;
  assign bus.rsp_ovf = rsp_ovf_q;

endmodule
